mac_sequencer: RTL and testbench

Bus-mastering sequencer for the DLX MAC unit. It accepts a dot-product or single-multiply command from the DLX control FSM and fetches operand pairs from the IOSIM memory bus using the as_N/wr_N/ACK_N handshake. It pulses MAC_RST/MAC_EN to drive the MAC datapath, then writes the accumulated result back to memory. It sits between the DLX control block, the MAC unit and the memory-bus master mux.

---
 rtl/mac_sequencer.sv | 147 ++++++++++++++
 tb/tb_mac_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Bus-mastering sequencer: fetches operand pairs, strobes the MAC, writes the result back.
// Bus accesses are 2 cycles minimum (idle + strobe) and stall on ACK_N; mul_mac=1 completes in 10 cycles.
module mac_sequencer #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK_IN,
  input  logic             RST_N_IN,
  input  logic             start,
  input  logic             mul_mac,
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_b,
  input  logic [AW-1:0]    dst,
  input  logic [LEN_W-1:0] len,
  output logic             as_N,
  output logic             wr_N,
  output logic [AW-1:0]    MAO,
  output logic [DW-1:0]    MDO,
  input  logic [DW-1:0]    DI,
  input  logic             ACK_N,
  output logic             MAC_EN,
  output logic             MAC_RST,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  input  logic [DW-1:0]    mac_acc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       MAC_STATE
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RD_A, S_RD_B, S_EXEC, S_SETTLE, S_WR, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             phase, phase_nxt;
  logic [AW-1:0]    ptr_a, ptr_b, dst_r;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    tmo;
  logic             ack, tmo_hit;

  // phase=0 is the idle (as_N high) cycle opening each access; phase=1 holds the strobe
  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    as_N      = 1'b1;
    wr_N      = 1'b1;
    MAO       = '0;
    MAC_EN    = 1'b0;
    MAC_RST   = 1'b0;
    done      = 1'b0;
    ack       = phase && !ACK_N;
    tmo_hit   = phase && ACK_N && (tmo == TW'(TIMEOUT - 1));
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLR;
      S_CLR: begin
        MAC_RST   = 1'b1;
        state_nxt = (cnt == '0) ? S_SETTLE : S_RD_A;
      end
      S_RD_A, S_RD_B, S_WR: begin
        as_N      = !phase;
        wr_N      = (state == S_WR) ? !phase : 1'b1;
        MAO       = (state == S_RD_A) ? ptr_a : (state == S_RD_B) ? ptr_b : dst_r;
        phase_nxt = 1'b1;
        if (ack) begin
          phase_nxt = 1'b0;
          state_nxt = (state == S_RD_A) ? S_RD_B : (state == S_RD_B) ? S_EXEC : S_DONE;
        end else if (tmo_hit) begin
          phase_nxt = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_EXEC: begin
        MAC_EN    = 1'b1;
        state_nxt = (cnt == LEN_W'(1)) ? S_SETTLE : S_RD_A;
      end
      S_SETTLE: state_nxt = S_WR;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      ptr_a <= '0;
      ptr_b <= '0;
      dst_r <= '0;
      cnt   <= '0;
      tmo   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      MDO   <= '0;
      err   <= 1'b0;
    end else begin
      tmo <= phase ? tmo + TW'(1) : '0;
      if (tmo_hit) err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          ptr_a <= base_a;
          ptr_b <= base_b;
          dst_r <= dst;
          cnt   <= mul_mac ? LEN_W'(1) : len;
          err   <= 1'b0;
        end
        S_RD_A:   if (ack) op_a <= DI;
        S_RD_B:   if (ack) op_b <= DI;
        S_EXEC: begin
          ptr_a <= ptr_a + AW'(4);
          ptr_b <= ptr_b + AW'(4);
          cnt   <= cnt - LEN_W'(1);
        end
        S_SETTLE: MDO <= mac_acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_IDLE:                 MAC_STATE = 2'd0;
      S_CLR, S_RD_A, S_RD_B:  MAC_STATE = 2'd1;
      S_EXEC, S_SETTLE:       MAC_STATE = 2'd2;
      default:                MAC_STATE = 2'd3;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: memory/bus responder, MAC accumulator model and a command-level scoreboard.
module tb_mac_sequencer;

  logic        CLK_IN = 1'b0;
  logic        RST_N_IN = 1'b0;
  logic        start = 1'b0;
  logic        mul_mac = 1'b0;
  logic [31:0] base_a = '0, base_b = '0, dst = '0;
  logic [15:0] len = '0;
  logic        as_N, wr_N, MAC_EN, MAC_RST, busy, done, err;
  logic [31:0] MAO, MDO, op_a, op_b;
  logic [31:0] DI = '0;
  logic        ACK_N = 1'b1;
  logic [31:0] mac_acc = '0;
  logic [1:0]  MAC_STATE;

  mac_sequencer #(.AW(32), .DW(32), .LEN_W(16), .TIMEOUT(255)) dut (
    .CLK_IN(CLK_IN), .RST_N_IN(RST_N_IN), .start(start), .mul_mac(mul_mac),
    .base_a(base_a), .base_b(base_b), .dst(dst), .len(len),
    .as_N(as_N), .wr_N(wr_N), .MAO(MAO), .MDO(MDO), .DI(DI), .ACK_N(ACK_N),
    .MAC_EN(MAC_EN), .MAC_RST(MAC_RST), .op_a(op_a), .op_b(op_b), .mac_acc(mac_acc),
    .busy(busy), .done(done), .err(err), .MAC_STATE(MAC_STATE)
  );

  always #5 CLK_IN = ~CLK_IN;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  // external MAC unit
  always @(posedge CLK_IN) begin
    if (!RST_N_IN || MAC_RST) mac_acc <= '0;
    else if (MAC_EN)          mac_acc <= mac_acc + op_a * op_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  // expected bus transactions and MAC operand pairs, in order
  logic [31:0] q_addr[$], q_dat[$], q_opa[$], q_opb[$];
  bit          q_wr[$];
  int          n_en, n_rst, n_wr, n_done, done_cyc, low_run, max_low, waits, wcnt;
  bit          hang, spurious, prev_ack, err_at_done;
  logic [31:0] hang_addr, hold_mao, last_wr_dat;

  always @(negedge CLK_IN) begin
    logic [31:0] edat;
    bit          ewr;
    if (!RST_N_IN) begin
      ACK_N = 1'b1; wcnt = 0; prev_ack = 0; low_run = 0;
    end else begin
      chk("idle_vs_busy", MAC_STATE == 2'd0, !busy);
      if (MAC_RST) begin n_rst++; chk("state_clr", MAC_STATE, 1); end
      if (done)    begin n_done++; done_cyc = cyc; err_at_done = err; chk("state_done", MAC_STATE, 3); end
      if (MAC_EN) begin
        n_en++;
        chk("state_exec", MAC_STATE, 2);
        chk("mac_en_expected", q_opa.size() != 0, 1);
        if (q_opa.size() != 0) begin
          chk("op_a", op_a, q_opa.pop_front());
          chk("op_b", op_b, q_opb.pop_front());
        end
      end
      if (prev_ack) chk("as_gap", as_N, 1);
      if (!as_N) begin
        chk("state_bus", MAC_STATE, wr_N ? 1 : 3);
        if (low_run == 0) hold_mao = MAO;
        else chk("mao_hold", MAO, hold_mao);
        low_run++;
        if (low_run > max_low) max_low = low_run;
        if (!(hang && MAO == hang_addr) && wcnt == waits) begin
          ACK_N = 1'b0;
          DI = rd(MAO);
          chk("bus_expected", q_addr.size() != 0, 1);
          if (q_addr.size() != 0) begin
            chk("addr", MAO, q_addr.pop_front());
            ewr  = q_wr.pop_front();
            edat = q_dat.pop_front();
            chk("wr_N", wr_N, !ewr);
            if (!wr_N) begin
              chk("wdata", MDO, edat);
              n_wr++;
              last_wr_dat = MDO;
              mem[MAO] = MDO;
            end
          end
          prev_ack = 1;
        end else begin
          ACK_N = 1'b1; wcnt++; prev_ack = 0;
        end
      end else begin
        ACK_N = spurious ? 1'b0 : 1'b1;
        wcnt = 0; prev_ack = 0; low_run = 0;
      end
    end
  end

  task automatic clear_model();
    q_addr.delete(); q_dat.delete(); q_wr.delete(); q_opa.delete(); q_opb.delete();
    n_en = 0; n_rst = 0; n_wr = 0; n_done = 0; max_low = 0; last_wr_dat = 32'hdead_beef;
  endtask

  task automatic run_cmd(input bit mm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [15:0] n, input int w,
                         input bit to, input bit poke, output int lat, output logic [31:0] wval);
    int          ne, t0;
    logic [31:0] ea, eb, sum;
    clear_model();
    waits = w; hang = to; hang_addr = a;
    ne  = mm ? 1 : int'(n);
    sum = 0;
    for (int i = 0; i < ne; i++) begin
      ea = rd(a + 32'(4 * i));
      eb = rd(b + 32'(4 * i));
      q_addr.push_back(a + 32'(4 * i)); q_wr.push_back(0); q_dat.push_back(0);
      q_addr.push_back(b + 32'(4 * i)); q_wr.push_back(0); q_dat.push_back(0);
      q_opa.push_back(ea); q_opb.push_back(eb);
      sum += ea * eb;
    end
    q_addr.push_back(d); q_wr.push_back(1); q_dat.push_back(sum);
    @(posedge CLK_IN); #1;
    mul_mac = mm; base_a = a; base_b = b; dst = d; len = n; start = 1'b1;
    t0 = cyc;
    @(posedge CLK_IN); #1;
    start = 1'b0; base_a = 32'hffff_0000; base_b = 32'hffff_0000; dst = 32'hffff_0000; len = 16'hffff;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    fork
      for (int k = 0; k < 3000 && n_done == 0; k++) @(posedge CLK_IN);
      if (poke) begin
        repeat (3) @(posedge CLK_IN);
        #1 start = 1'b1; mul_mac = 1'b1; base_a = 32'h500; dst = 32'h900;
        @(posedge CLK_IN);
        #1 start = 1'b0;
      end
    join
    repeat (2) @(posedge CLK_IN);
    #1;
    chk("done_pulses", n_done, 1);
    chk("mac_rst_pulses", n_rst, 1);
    chk("mac_en_pulses", n_en, to ? 0 : ne);
    chk("writes", n_wr, to ? 0 : 1);
    chk("err_at_done", err_at_done, to);
    chk("err_sticky", err, to);
    chk("busy_end", busy, 0);
    if (!to) chk("bus_all_seen", q_addr.size(), 0);
    lat  = done_cyc - t0;
    wval = last_wr_dat;
  endtask

  initial begin
    int          lat;
    logic [31:0] w;
    bit          found;
    clear_model();
    waits = 0; hang = 0; spurious = 0; hang_addr = '0;
    repeat (3) @(posedge CLK_IN);
    #1;
    chk("rst_as_N", as_N, 1);   chk("rst_wr_N", wr_N, 1);
    chk("rst_MAO", MAO, 0);     chk("rst_MDO", MDO, 0);
    chk("rst_MAC_EN", MAC_EN, 0); chk("rst_MAC_RST", MAC_RST, 0);
    chk("rst_op_a", op_a, 0);   chk("rst_op_b", op_b, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_err", err, 0);     chk("rst_state", MAC_STATE, 0);
    RST_N_IN = 1'b1;

    // single multiply, zero-wait
    mem[32'h100] = 3; mem[32'h200] = 7;
    run_cmd(1, 32'h100, 32'h200, 32'h300, 16'd9, 0, 0, 0, lat, w);
    chk("mul_latency", lat, 10);
    chk("mul_result", w, 21);
    chk("mul_mem", rd(32'h300), 21);

    // 4-element dot product, two wait states
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
      mem[32'h200 + 32'(4 * i)] = 32'(i + 5);
    end
    run_cmd(0, 32'h100, 32'h200, 32'h400, 16'd4, 2, 0, 0, lat, w);
    chk("dot4_result", w, 70);

    // zero-length writes the cleared accumulator
    mem[32'h500] = 99;
    run_cmd(0, 32'h100, 32'h200, 32'h500, 16'd0, 0, 0, 0, lat, w);
    chk("len0_result", w, 0);
    chk("len0_mem", rd(32'h500), 0);

    // timeout on first read
    mem[32'h600] = 55;
    run_cmd(0, 32'h100, 32'h200, 32'h600, 16'd2, 0, 1, 0, lat, w);
    chk("timeout_low_cycles", max_low, 255);
    chk("timeout_no_write", rd(32'h600), 55);

    // restart while busy and stray ACK_N both ignored; also clears err
    spurious = 1;
    run_cmd(0, 32'h100, 32'h200, 32'h700, 16'd3, 1, 0, 1, lat, w);
    chk("poke_result", w, 38);
    chk("poke_no_stray_write", rd(32'h900), 0);
    spurious = 0;

    // reset while RD_B is strobing
    clear_model();
    hang = 1; hang_addr = 32'h200; waits = 0;
    q_addr.push_back(32'h100); q_wr.push_back(0); q_dat.push_back(0);
    q_addr.push_back(32'h200); q_wr.push_back(0); q_dat.push_back(0);
    @(posedge CLK_IN); #1;
    mul_mac = 1; base_a = 32'h100; base_b = 32'h200; dst = 32'h800; start = 1'b1;
    @(posedge CLK_IN); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK_IN);
      if (!as_N && MAO == 32'h200) found = 1;
    end
    chk("rdb_reached", found, 1);
    @(posedge CLK_IN); #1 RST_N_IN = 1'b0;
    @(posedge CLK_IN); #1;
    chk("rstmid_as_N", as_N, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_state", MAC_STATE, 0);
    repeat (2) @(posedge CLK_IN);
    #1 RST_N_IN = 1'b1; hang = 0;
    repeat (20) @(posedge CLK_IN);
    #1;
    chk("rstmid_no_mac_en", n_en, 0);
    chk("rstmid_no_write", n_wr, 0);
    chk("rstmid_mem", rd(32'h800), 0);
    chk("rstmid_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
